// File: rtl/fetch_if.sv
// Fetch stage port bundle: hazard/branch controls, instruction memory, and IF/ID outputs.
// The slave modport is the fetch stage; the master modport is whatever drives it.
interface fetch_if;
   logic        PC_WriteEnable;
   logic        IFID_WriteEnable;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic [31:0] IM_Instruction;
   logic [31:0] IM_Address;
   logic [31:0] IFID_Instruction;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_Valid;
   logic [1:0]  FetchState;
   logic [15:0] StallCount;
   logic [15:0] FlushCount;

   modport slave (
      input  PC_WriteEnable,
      input  IFID_WriteEnable,
      input  BranchTaken,
      input  BranchTarget,
      input  IM_Instruction,
      output IM_Address,
      output IFID_Instruction,
      output IFID_PCPlus4,
      output IFID_Valid,
      output FetchState,
      output StallCount,
      output FlushCount
   );

   modport master (
      output PC_WriteEnable,
      output IFID_WriteEnable,
      output BranchTaken,
      output BranchTarget,
      output IM_Instruction,
      input  IM_Address,
      input  IFID_Instruction,
      input  IFID_PCPlus4,
      input  IFID_Valid,
      input  FetchState,
      input  StallCount,
      input  FlushCount
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, fetch-state tracker
// and saturating stall/flush event counters.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | both enables high, no redirect: normal sequential fetch
// ST_STALL | at least one enable low, no redirect: PC and/or IF/ID held
// ST_FLUSH | redirect taken this cycle: PC loaded, IF/ID holds a bubble
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic   Clock,
   input  logic   Reset,
   fetch_if.slave fif
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_STALL = 2'b01,
      ST_FLUSH = 2'b10
   } fetch_state_t;

   localparam logic [31:0] C_PC_ALIGN = 32'hFFFF_FFFC;
   localparam logic [31:0] C_RESET_PC = RESET_PC & C_PC_ALIGN;

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;

   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_target;

   logic [31:0] r_ifid_instr;
   logic [31:0] r_ifid_pc4;
   logic        r_ifid_valid;
   logic [31:0] w_ifid_instr_nxt;
   logic [31:0] w_ifid_pc4_nxt;
   logic        w_ifid_valid_nxt;

   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;
   logic        w_stall_inc;
   logic        w_flush_inc;

   // Masking keeps the PC word-aligned no matter what the resolver hands us.
   assign w_target   = fif.BranchTarget & C_PC_ALIGN;
   assign w_pc_plus4 = r_pc + 32'd4;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = ST_RUN;
      w_pc_nxt         = r_pc;
      w_ifid_instr_nxt = r_ifid_instr;
      w_ifid_pc4_nxt   = r_ifid_pc4;
      w_ifid_valid_nxt = r_ifid_valid;

      if (fif.BranchTaken) begin
         w_state_nxt      = ST_FLUSH;
         w_pc_nxt         = w_target;
         w_ifid_instr_nxt = 32'h0000_0000;
         w_ifid_pc4_nxt   = 32'h0000_0000;
         w_ifid_valid_nxt = 1'b0;
      end else begin
         if (!fif.PC_WriteEnable || !fif.IFID_WriteEnable) begin
            w_state_nxt = ST_STALL;
         end
         if (fif.PC_WriteEnable) begin
            w_pc_nxt = w_pc_plus4;
         end
         // IF/ID captures against the pre-update PC even when the PC is held.
         if (fif.IFID_WriteEnable) begin
            w_ifid_instr_nxt = fif.IM_Instruction;
            w_ifid_pc4_nxt   = w_pc_plus4;
            w_ifid_valid_nxt = 1'b1;
         end
      end
   end

   assign w_stall_inc = (w_state_nxt == ST_STALL);
   assign w_flush_inc = fif.BranchTaken;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_pc         <= C_RESET_PC;
         r_ifid_instr <= 32'h0000_0000;
         r_ifid_pc4   <= 32'h0000_0000;
         r_ifid_valid <= 1'b0;
      end else begin
         r_pc         <= w_pc_nxt;
         r_ifid_instr <= w_ifid_instr_nxt;
         r_ifid_pc4   <= w_ifid_pc4_nxt;
         r_ifid_valid <= w_ifid_valid_nxt;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_stall_cnt <= 16'h0000;
         r_flush_cnt <= 16'h0000;
      end else begin
         if (w_stall_inc && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
         if (w_flush_inc && (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
         end
      end
   end

   assign fif.IM_Address       = r_pc;
   assign fif.IFID_Instruction = r_ifid_instr;
   assign fif.IFID_PCPlus4     = r_ifid_pc4;
   assign fif.IFID_Valid       = r_ifid_valid;
   assign fif.FetchState       = r_state;
   assign fif.StallCount       = r_stall_cnt;
   assign fif.FlushCount       = r_flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: instruction memory returns 0xA0 + address, and every
// step checks the registered outputs 1 time unit after the rising edge.
module tb_fetch_stage;

   logic Clock;
   logic Reset;
   int   n_tests;
   int   n_fail;

   fetch_if fif ();

   fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
      .Clock (Clock),
      .Reset (Reset),
      .fif   (fif.slave)
   );

   assign fif.IM_Instruction = 32'h0000_00A0 + fif.IM_Address;

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic br, input logic [31:0] tgt, input logic pcwe, input logic ifwe);
      fif.BranchTaken      = br;
      fif.BranchTarget     = tgt;
      fif.PC_WriteEnable   = pcwe;
      fif.IFID_WriteEnable = ifwe;
   endtask

   task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                          input logic [31:0] pc4, input logic vld, input logic [1:0] st,
                          input logic [15:0] sc, input logic [15:0] fc);
      chk({tag, ".pc"},    fif.IM_Address,              pc);
      chk({tag, ".instr"}, fif.IFID_Instruction,        ins);
      chk({tag, ".pc4"},   fif.IFID_PCPlus4,            pc4);
      chk({tag, ".valid"}, {31'd0, fif.IFID_Valid},     {31'd0, vld});
      chk({tag, ".state"}, {30'd0, fif.FetchState},     {30'd0, st});
      chk({tag, ".stall"}, {16'd0, fif.StallCount},     {16'd0, sc});
      chk({tag, ".flush"}, {16'd0, fif.FlushCount},     {16'd0, fc});
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;

      // reset with enables low: all outputs at reset values
      Reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      tick();
      chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 16'd0, 16'd0);

      // sequential fetch, PC 0 -> 4 -> 8
      Reset = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      chk_all("run1", 32'h4, 32'hA0, 32'h4, 1'b1, 2'b00, 16'd0, 16'd0);
      tick();
      chk_all("run2", 32'h8, 32'hA4, 32'h8, 1'b1, 2'b00, 16'd0, 16'd0);

      // two-cycle full stall at PC=8
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      chk_all("stall1", 32'h8, 32'hA4, 32'h8, 1'b1, 2'b01, 16'd1, 16'd0);
      tick();
      chk_all("stall2", 32'h8, 32'hA4, 32'h8, 1'b1, 2'b01, 16'd2, 16'd0);

      drive(1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      chk_all("release", 32'hC, 32'hA8, 32'hC, 1'b1, 2'b00, 16'd2, 16'd0);

      // PC advances, IF/ID held
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      tick();
      chk_all("mixA", 32'h10, 32'hA8, 32'hC, 1'b1, 2'b01, 16'd3, 16'd0);

      // PC held, IF/ID reloads from unchanged PC=0x10
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      tick();
      chk_all("mixB", 32'h10, 32'hB0, 32'h14, 1'b1, 2'b01, 16'd4, 16'd0);

      // redirect with both enables low; low target bits dropped
      drive(1'b1, 32'h0000_0103, 1'b0, 1'b0);
      tick();
      chk_all("flush1", 32'h100, 32'h0, 32'h0, 1'b0, 2'b10, 16'd4, 16'd1);

      // back-to-back redirect to top of address space
      drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
      tick();
      chk_all("flush2", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 2'b10, 16'd4, 16'd2);

      // PC+4 wraps modulo 2^32, IM data 0xA0+0xFFFFFFFC wraps too
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      chk_all("wrap", 32'h0, 32'h9C, 32'h0, 1'b1, 2'b00, 16'd4, 16'd2);

      // long stall saturates StallCount (starts at 4)
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 65540; i++) tick();
      chk_all("sat", 32'h0, 32'h9C, 32'h0, 1'b1, 2'b01, 16'hFFFF, 16'd2);
      tick();
      chk("sat_hold", {16'd0, fif.StallCount}, 32'h0000_FFFF);

      // reset overrides a redirect and both enables mid-stall
      Reset = 1'b1;
      drive(1'b1, 32'h0000_0200, 1'b1, 1'b1);
      tick();
      chk_all("rst_br", 32'h0, 32'h0, 32'h0, 1'b0, 2'b00, 16'd0, 16'd0);

      // first cycle after reset fetches normally from RESET_PC
      Reset = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 1'b1);
      tick();
      chk_all("post_rst", 32'h4, 32'hA0, 32'h4, 1'b1, 2'b00, 16'd0, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high; sampled on the rising edge of Clock.
REQ-004 Port: PC_WriteEnable  input  1  from hazard detection; 1 = PC may advance.
REQ-005 Port: IFID_WriteEnable  input  1  from hazard detection; 1 = IF/ID register may load.
REQ-006 Port: BranchTaken  input  1  redirect request from branch/jump resolution.
REQ-007 Port: BranchTarget  input  32  redirect address; bits [1:0] ignored.
REQ-008 Port: IM_Instruction  input  32  instruction memory read data for IM_Address, combinational, same cycle.
REQ-009 Port: IM_Address  output  32  current PC; drives instruction memory.
REQ-010 Port: IFID_Instruction  output  32  registered instruction to decode.
REQ-011 Port: IFID_PCPlus4  output  32  registered PC+4 of the IFID_Instruction.
REQ-012 Port: IFID_Valid  output  1  1 = IFID_Instruction is real; 0 = bubble.
REQ-013 Port: FetchState  output  2  registered state: 2'b00 RUN, 2'b01 STALL, 2'b10 FLUSH.
REQ-014 Port: StallCount  output  16  saturating count of stall cycles.
REQ-015 Port: FlushCount  output  16  saturating count of redirects.

Function
REQ-016 IM_Address SHALL equal the PC register; PC[1:0] SHALL always be 2'b00.
REQ-017 Per-cycle priority SHALL be: Reset > BranchTaken > enables.
REQ-018 BranchTaken=1: PC <= {BranchTarget[31:2],2'b00} regardless of PC_WriteEnable.
REQ-019 BranchTaken=1: IFID_Instruction <= 32'h0, IFID_PCPlus4 <= 32'h0, IFID_Valid <= 0, regardless of IFID_WriteEnable.
REQ-020 BranchTaken=0, PC_WriteEnable=1: PC <= PC + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-021 BranchTaken=0, PC_WriteEnable=0: PC SHALL hold.
REQ-022 BranchTaken=0, IFID_WriteEnable=1: IFID_Instruction <= IM_Instruction, IFID_PCPlus4 <= PC + 4 (pre-update PC), IFID_Valid <= 1.
REQ-023 BranchTaken=0, IFID_WriteEnable=0: all IFID outputs SHALL hold their values.
REQ-024 Mixed enables SHALL be honoured independently: PC_WriteEnable=1/IFID_WriteEnable=0 advances PC with IF/ID held; PC_WriteEnable=0/IFID_WriteEnable=1 reloads IF/ID from the unchanged PC.
REQ-025 FetchState next value: FLUSH if BranchTaken=1; else STALL if IFID_WriteEnable=0 or PC_WriteEnable=0; else RUN.
REQ-026 FetchState transitions SHALL be permitted between any two states in one cycle; encoding 2'b11 SHALL never appear.
REQ-027 StallCount SHALL increment by 1 each cycle in which next FetchState is STALL; it SHALL hold at 16'hFFFF.
REQ-028 FlushCount SHALL increment by 1 each cycle BranchTaken=1 (Reset=0); it SHALL hold at 16'hFFFF.
REQ-029 Latency: an instruction presented on IM_Instruction SHALL appear on IFID_Instruction one cycle later.

Reset
REQ-030 Reset=1 at a rising edge SHALL set PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, FetchState=RUN, StallCount=0, FlushCount=0.
REQ-031 Reset SHALL override BranchTaken and both enables in the same cycle, including mid-stall and mid-flush.
REQ-032 In the first cycle after Reset deasserts, fetch SHALL proceed normally from RESET_PC.

Verification
REQ-033 Reset, then 3 cycles with both enables=1, IM returning 0xA0+PC -> PC 0,4,8,12; IFID_PCPlus4 4,8,12; IFID_Valid=1; FetchState=RUN.
REQ-034 At PC=8, hold both enables=0 for 2 cycles -> PC stays 8, IFID frozen, FetchState=STALL, StallCount=2; release -> PC=12 next cycle.
REQ-035 BranchTaken=1, BranchTarget=0x0000_0103, both enables=0 -> PC=0x100, IFID_Instruction=0, IFID_Valid=0, FetchState=FLUSH, FlushCount=1, StallCount unchanged.
REQ-036 PC=0xFFFF_FFFC, both enables=1 -> PC=0x0000_0000, IFID_PCPlus4=0x0000_0000.
REQ-037 Force StallCount to 0xFFFF via long stall -> stays 0xFFFF; Reset=1 together with BranchTaken=1 -> all outputs at reset values, FlushCount=0.
